wb_dsp_bus_master: RTL

Wishbone classic master that the DSP engine uses to fetch coefficients and samples and to write results to system memory. The engine issues a single- or multi-word request. The block runs one Wishbone transaction per word at incrementing addresses, handling ack, err and rty, with a response timeout. It sits between the DSP datapath and the system interconnect, on the opposite side from the DSP's slave register file.

---
 rtl/wb_dsp_bus_master.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_dsp_bus_master.sv
// -----------------------------------------------------------------------------
// wb_dsp_bus_master
//
// Wishbone classic master used by the DSP engine to fetch coefficients and
// samples and to write results to system memory. A request of 1..256 words is
// split into one classic Wishbone cycle per word at incrementing byte
// addresses. Every word is followed by a one-cycle strobe gap. err, rty and a
// response timeout abort the request.
//
// Ports
//   wb_clk, wb_rst          clock, asynchronous active-high reset
//   req_start               one-cycle request pulse, sampled only in IDLE
//   req_we/addr/len/sel     direction, first byte address, words-1, byte selects
//   wr_data / wr_data_pop   write word from the engine / "word taken, show next"
//   rd_data / rd_valid      registered read word / one-cycle valid pulse
//   busy, done              request in progress / one-cycle completion pulse
//   error, err_code         abort flag and cause, held until the next request
//   wb_*_o / wb_*_i         Wishbone classic master port (cti/bte tied to 0)
// -----------------------------------------------------------------------------
module wb_dsp_bus_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int TIMEOUT   = 16,
    parameter int RETRY_MAX = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          req_start,
    input  logic          req_we,
    input  logic [aw-1:0] req_addr,
    input  logic [7:0]    req_len,
    input  logic [3:0]    req_sel,
    input  logic [dw-1:0] wr_data,
    output logic          wr_data_pop,
    output logic [dw-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [1:0] {IDLE, BUS, GAP, DONE} state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BUS     = 2'b01,
        ERR_RETRY   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0]    TMO_LIM  = 8'(TIMEOUT);
    localparam logic [7:0]    RTY_LIM  = 8'(RETRY_MAX);
    localparam logic [aw-1:0] ADR_STEP = aw'(4);

    state_t        state_q;
    err_code_t     err_code_q;
    err_code_t     abort_code_d;
    logic          abort_d;
    logic [7:0]    len_q;
    logic [7:0]    beat_q;
    logic [7:0]    retry_q;
    logic [7:0]    tmo_q;
    logic [7:0]    tmo_d;
    logic [aw-1:0] adr_q;
    logic [aw-1:0] adr_d;
    logic [dw-1:0] dat_q;
    logic [dw-1:0] rd_data_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          cyc_q;
    logic          stb_q;
    logic          pop_q;
    logic          rd_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          last_beat;

    assign tmo_d     = tmo_q + 8'd1;
    assign adr_d     = adr_q + ADR_STEP;
    assign last_beat = (beat_q == len_q);

    // Abort decision for the current BUS cycle. err wins over ack, and any
    // real response wins over a timeout landing in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (no latch).
        abort_d      = 1'b0;
        abort_code_d = ERR_NONE;
        if (wb_err_i) begin
            abort_d      = 1'b1;
            abort_code_d = ERR_BUS;
        end else if (wb_ack_i) begin
            abort_d      = 1'b0;
        end else if (wb_rty_i) begin
            if (retry_q == RTY_LIM) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_RETRY;
            end
        end else if (tmo_d == TMO_LIM) begin
            abort_d      = 1'b1;
            abort_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            // NOTE: the data registers are reset too, because they drive
            // outputs that must read 0 from reset onwards.
            state_q    <= IDLE;
            err_code_q <= ERR_NONE;
            len_q      <= '0;
            beat_q     <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_data_q  <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            pop_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. The pulses default
            // low here and are raised only in the branch that fires them.
            pop_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_start) begin
                        state_q    <= BUS;
                        we_q       <= req_we;
                        adr_q      <= req_addr;
                        len_q      <= req_len;
                        sel_q      <= req_sel;
                        dat_q      <= wr_data;
                        beat_q     <= '0;
                        retry_q    <= '0;
                        tmo_q      <= '0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                BUS: begin
                    if (abort_d) begin
                        // The failing word produces no pop and no rd_valid.
                        state_q    <= DONE;
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= abort_code_d;
                        done_q     <= 1'b1;
                    end else if (wb_ack_i) begin
                        if (we_q) begin
                            pop_q      <= 1'b1;
                        end else begin
                            rd_data_q  <= wb_dat_i;
                            rd_valid_q <= 1'b1;
                        end
                        stb_q <= 1'b0;
                        if (last_beat) begin
                            state_q <= DONE;
                            cyc_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= GAP;
                            adr_q   <= adr_d;
                            beat_q  <= beat_q + 8'd1;
                            retry_q <= '0;
                        end
                    end else if (wb_rty_i) begin
                        // Same word is reissued after the gap.
                        state_q <= GAP;
                        stb_q   <= 1'b0;
                        retry_q <= retry_q + 8'd1;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                GAP: begin
                    // One strobe-free cycle stops a registered-ack slave from
                    // acking the same word twice. pop_q is high only when the
                    // previous word was an acked write, so a retried word
                    // keeps its data.
                    tmo_q <= '0;
                    if (pop_q) begin
                        dat_q <= wr_data;
                    end
                    stb_q   <= 1'b1;
                    state_q <= BUS;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_data_pop = pop_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_cti_o    = 3'b000;
    assign wb_bte_o    = 2'b00;

endmodule
